// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN constants (class count, image pixels, score width) and scorer state enum
package cnn_pkg;
  localparam int NUM_CLASS = 10;
  localparam int IMG_PIX = 784;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, FIN} scorer_state_t;
endpackage

// File: rtl/argmax_acc.sv
// argmax_acc: running signed max/index; first loads unconditionally, later only strictly greater (ports: clk reset in_valid first idx score -> max_idx max_score)
module argmax_acc #(
  parameter int DATA_W = 32,
  parameter int CLS_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     first,
  input  logic [CLS_W-1:0]         idx,
  input  logic signed [DATA_W-1:0] score,
  output logic [CLS_W-1:0]         max_idx,
  output logic signed [DATA_W-1:0] max_score
);
  always_ff @(posedge clk) begin
    if (reset) begin
      max_idx <= '0;
      max_score <= '0;
    end else if (in_valid && (first || score > max_score)) begin
      max_idx <= idx;
      max_score <= score;
    end
  end
endmodule

// File: rtl/fc_argmax_scorer.sv
// fc_argmax_scorer: per-image argmax over FC scores vs label memory (ports: clk reset start -> busy done; fc/lbl read ports; pred valid/ready stream; correct_cnt)
module fc_argmax_scorer
  import cnn_pkg::*;
#(
  parameter int IMG_NUM = 250,
  parameter int NUM_CLASS = cnn_pkg::NUM_CLASS,
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int RD_LAT = 1,
  parameter int OUT_BW = $clog2(IMG_NUM * NUM_CLASS),
  parameter int IMG_W = $clog2(IMG_NUM),
  parameter int CLS_W = $clog2(NUM_CLASS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     fc_rd_en,
  output logic [OUT_BW-1:0]        fc_rd_addr,
  input  logic signed [DATA_W-1:0] fc_rd_data,
  output logic                     lbl_rd_en,
  output logic [IMG_W-1:0]         lbl_rd_addr,
  input  logic [CLS_W-1:0]         lbl_rd_data,
  output logic                     pred_valid,
  input  logic                     pred_ready,
  output logic [IMG_W-1:0]         pred_img,
  output logic [CLS_W-1:0]         pred_class,
  output logic signed [DATA_W-1:0] pred_score,
  output logic                     pred_hit,
  output logic [IMG_W:0]           correct_cnt
);
  localparam int D_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  scorer_state_t state;
  logic [CLS_W-1:0] k;
  logic [IMG_W-1:0] img;
  logic [OUT_BW-1:0] base;
  logic [D_W-1:0] dcnt;
  logic [CLS_W-1:0] lbl_q;
  logic [CLS_W:0] dl [RD_LAT];
  logic tag_valid;
  logic [CLS_W-1:0] tag_k;
  assign tag_valid = dl[RD_LAT-1][CLS_W];
  assign tag_k = dl[RD_LAT-1][CLS_W-1:0];
  assign pred_img = img;
  assign pred_hit = pred_valid && (pred_class == lbl_q);
  argmax_acc #(.DATA_W(DATA_W), .CLS_W(CLS_W)) u_acc (
    .clk(clk),
    .reset(reset),
    .in_valid(tag_valid),
    .first(tag_k == '0),
    .idx(tag_k),
    .score(fc_rd_data),
    .max_idx(pred_class),
    .max_score(pred_score)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {fc_rd_en, k};
      for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      img <= '0;
      base <= '0;
      dcnt <= '0;
      lbl_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fc_rd_en <= 1'b0;
      fc_rd_addr <= '0;
      lbl_rd_en <= 1'b0;
      lbl_rd_addr <= '0;
      pred_valid <= 1'b0;
      correct_cnt <= '0;
    end else begin
      done <= 1'b0;
      lbl_rd_en <= 1'b0;
      if (tag_valid && tag_k == '0) lbl_q <= lbl_rd_data;
      case (state)
        IDLE: if (start) begin
          state <= READ;
          busy <= 1'b1;
          img <= '0;
          base <= '0;
          k <= '0;
          correct_cnt <= '0;
          fc_rd_en <= 1'b1;
          fc_rd_addr <= '0;
          lbl_rd_en <= 1'b1;
          lbl_rd_addr <= '0;
        end
        READ: if (k == CLS_W'(NUM_CLASS - 1)) begin
          state <= DRAIN;
          fc_rd_en <= 1'b0;
          dcnt <= '0;
        end else begin
          k <= k + 1'b1;
          fc_rd_addr <= fc_rd_addr + 1'b1;
        end
        DRAIN: if (dcnt == D_W'(RD_LAT - 1)) begin
          state <= EMIT;
          pred_valid <= 1'b1;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        EMIT: if (pred_ready) begin
          pred_valid <= 1'b0;
          correct_cnt <= correct_cnt + (IMG_W+1)'(pred_hit);
          if (img == IMG_W'(IMG_NUM - 1)) begin
            state <= FIN;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= READ;
            img <= img + 1'b1;
            base <= base + OUT_BW'(NUM_CLASS);
            k <= '0;
            fc_rd_en <= 1'b1;
            fc_rd_addr <= base + OUT_BW'(NUM_CLASS);
            lbl_rd_en <= 1'b1;
            lbl_rd_addr <= img + 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_argmax_scorer.sv
// tb_fc_argmax_scorer: directed table-driven bench for fc_argmax_scorer at RD_LAT=1 and RD_LAT=2
module tb_fc_argmax_scorer;
  typedef struct {
    logic [1:0]         img;
    logic [3:0]         cls;
    logic signed [31:0] score;
    logic               hit;
    logic [2:0]         cnt;
  } exp_t;
  exp_t tbl [3];
  logic clk;
  logic rst [2];
  logic start [2];
  logic rdy [2];
  logic busy [2];
  logic done [2];
  logic fc_en [2];
  logic lbl_en [2];
  logic pv [2];
  logic hit [2];
  logic [4:0] fc_addr [2];
  logic [1:0] lbl_addr [2];
  logic [1:0] pimg [2];
  logic [3:0] pcls [2];
  logic [3:0] lbl_data [2];
  logic [2:0] cnt [2];
  logic signed [31:0] fc_data [2];
  logic signed [31:0] pscore [2];
  logic signed [31:0] f1 [2];
  logic signed [31:0] f2 [2];
  logic [3:0] l1 [2];
  logic [3:0] l2 [2];
  logic signed [31:0] fc_mem [32];
  logic [3:0] lbl_mem [4];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fc_argmax_scorer #(.IMG_NUM(3), .NUM_CLASS(10), .DATA_W(32), .RD_LAT(1)) u0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .fc_rd_en(fc_en[0]), .fc_rd_addr(fc_addr[0]), .fc_rd_data(fc_data[0]),
    .lbl_rd_en(lbl_en[0]), .lbl_rd_addr(lbl_addr[0]), .lbl_rd_data(lbl_data[0]),
    .pred_valid(pv[0]), .pred_ready(rdy[0]), .pred_img(pimg[0]), .pred_class(pcls[0]),
    .pred_score(pscore[0]), .pred_hit(hit[0]), .correct_cnt(cnt[0])
  );
  fc_argmax_scorer #(.IMG_NUM(3), .NUM_CLASS(10), .DATA_W(32), .RD_LAT(2)) u1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .fc_rd_en(fc_en[1]), .fc_rd_addr(fc_addr[1]), .fc_rd_data(fc_data[1]),
    .lbl_rd_en(lbl_en[1]), .lbl_rd_addr(lbl_addr[1]), .lbl_rd_data(lbl_data[1]),
    .pred_valid(pv[1]), .pred_ready(rdy[1]), .pred_img(pimg[1]), .pred_class(pcls[1]),
    .pred_score(pscore[1]), .pred_hit(hit[1]), .correct_cnt(cnt[1])
  );

  // Memories return garbage when not enabled so untagged consumption is visible.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      f1[u] <= fc_en[u] ? fc_mem[fc_addr[u]] : 32'sh7fff_ffff;
      l1[u] <= lbl_en[u] ? lbl_mem[lbl_addr[u]] : 4'hf;
      f2[u] <= f1[u];
      l2[u] <= l1[u];
    end
  end
  assign fc_data[0] = f1[0];
  assign lbl_data[0] = l1[0];
  assign fc_data[1] = f2[1];
  assign lbl_data[1] = l2[1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int u);
    return {busy[u], done[u], fc_en[u], fc_addr[u], lbl_en[u], lbl_addr[u], pv[u],
            pimg[u], pcls[u], pscore[u], hit[u], cnt[u]};
  endfunction

  task automatic do_reset(input int u);
    rst[u] = 1'b1;
    start[u] = 1'b0;
    rdy[u] = 1'b0;
    @(negedge clk);
    chk("reset_outputs_zero", outs(u), 64'd0);
    rst[u] = 1'b0;
  endtask

  task automatic start_batch(input int u);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    chk("busy_after_start", 64'(busy[u]), 64'd1);
  endtask

  task automatic run_image(input int u, input int lat, input int i, input int stall, input bit poke);
    bit ok = 1'b1;
    int d = 0;
    logic [4:0] exp_addr;
    for (int k = 0; k < 10; k++) begin
      exp_addr = 5'(i * 10 + k);
      if (!(fc_en[u] && fc_addr[u] == exp_addr && busy[u] && lbl_en[u] == (k == 0)
            && (k != 0 || lbl_addr[u] == 2'(i)))) ok = 1'b0;
      if (poke && k == 3) start[u] = 1'b1;
      @(negedge clk);
      start[u] = 1'b0;
    end
    chk("read_trace", 64'(ok), 64'd1);
    while (!pv[u] && d < 20) begin
      if (fc_en[u] || lbl_en[u]) ok = 1'b0;
      @(negedge clk);
      d++;
    end
    chk("drain_cycles", 64'(d), 64'(lat));
    chk("drain_no_reads", 64'(ok), 64'd1);
    chk("pred_img", 64'(pimg[u]), 64'(tbl[i].img));
    chk("pred_class", 64'(pcls[u]), 64'(tbl[i].cls));
    chk("pred_score", pscore[u], tbl[i].score);
    chk("pred_hit", 64'(hit[u]), 64'(tbl[i].hit));
    for (int s = 0; s < stall; s++) begin
      if (!pv[u] || pcls[u] != tbl[i].cls || pscore[u] != tbl[i].score || pimg[u] != tbl[i].img
          || hit[u] != tbl[i].hit || fc_en[u] || lbl_en[u]) ok = 1'b0;
      @(negedge clk);
    end
    if (stall > 0) chk("stall_stable", 64'(ok), 64'd1);
    rdy[u] = 1'b1;
    @(negedge clk);
    rdy[u] = 1'b0;
    chk("valid_drop", 64'(pv[u]), 64'd0);
    chk("correct_cnt", 64'(cnt[u]), 64'(tbl[i].cnt));
    if (i < 2) begin
      chk("resume_read", {fc_en[u], fc_addr[u]}, {1'b1, 5'((i + 1) * 10)});
    end else begin
      chk("done_pulse", {done[u], busy[u]}, {1'b1, 1'b0});
      start[u] = 1'b1;
      @(negedge clk);
      start[u] = 1'b0;
      chk("after_done", {done[u], busy[u], fc_en[u], cnt[u]}, {1'b0, 1'b0, 1'b0, 3'd2});
      repeat (3) @(negedge clk);
      chk("cnt_held", {busy[u], done[u], cnt[u]}, {1'b0, 1'b0, 3'd2});
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1;
      start[u] = 1'b0;
      rdy[u] = 1'b0;
    end
    for (int a = 0; a < 32; a++) fc_mem[a] = 32'sd0;
    for (int k = 0; k < 10; k++) fc_mem[k] = 32'(k);
    fc_mem[7] = 32'sd100;
    for (int k = 10; k < 20; k++) fc_mem[k] = 32'sd5;
    for (int k = 20; k < 30; k++) fc_mem[k] = -32'sd50;
    fc_mem[24] = -32'sd4;
    fc_mem[29] = -32'sd3;
    lbl_mem[0] = 4'd7;
    lbl_mem[1] = 4'd3;
    lbl_mem[2] = 4'd9;
    lbl_mem[3] = 4'd0;
    tbl[0] = '{img: 2'd0, cls: 4'd7, score: 32'sd100, hit: 1'b1, cnt: 3'd1};
    tbl[1] = '{img: 2'd1, cls: 4'd0, score: 32'sd5, hit: 1'b0, cnt: 3'd1};
    tbl[2] = '{img: 2'd2, cls: 4'd9, score: -32'sd3, hit: 1'b1, cnt: 3'd2};
    for (int u = 0; u < 2; u++) begin
      do_reset(u);
      start_batch(u);
      run_image(u, u + 1, 0, 0, 1'b0);
      run_image(u, u + 1, 1, 6, 1'b1);
      run_image(u, u + 1, 2, 0, 1'b0);
      start_batch(u);
      run_image(u, u + 1, 0, 0, 1'b0);
      repeat (4) @(negedge clk);
      rst[u] = 1'b1;
      @(negedge clk);
      chk("mid_reset_outputs_zero", outs(u), 64'd0);
      rst[u] = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_done_after_abort", outs(u), 64'd0);
      start_batch(u);
      for (int i = 0; i < 3; i++) run_image(u, u + 1, i, (i == 0) ? 2 : 0, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
